motor_pwm_mc: RTL and testbench
===============================

MOTOR_PWM_MC -- requirements
Module: motor_pwm_mc

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, the number of independent motor channels (1..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, the width of the period counter and duty values.
REQ-003 The block SHALL have parameter PERIOD, default 100, the refclk cycles per PWM period (2..2^CNT_W-1).
REQ-004 The block SHALL have parameter DEADTIME, default 16, the refclk cycles of forced-low output on a direction reversal (>=1).
REQ-005 The block SHALL have parameter RAMP_STEP, default 5, the maximum effective-duty change per period; 0 means immediate.
REQ-006 The block SHALL have port refclk, input, 1, the clock for all logic.
REQ-007 The block SHALL have port resetN, input, 1, a synchronous active-low reset.
REQ-008 The block SHALL have port duty_cycle, input, NUM_CH*CNT_W, the target high count per channel (channel n at bits [n*CNT_W +: CNT_W]).
REQ-009 The block SHALL have port control, input, NUM_CH*2, per channel bit0=enable and bit1=direction requested.
REQ-010 The block SHALL have port sig_out, output, NUM_CH, the per-channel registered PWM output.
REQ-011 The block SHALL have port dir_out, output, NUM_CH, the per-channel registered direction.
REQ-012 The block SHALL have port dead_active, output, NUM_CH, which is high while a channel is in DEAD.
REQ-013 The block SHALL have port period_tick, output, 1, a one-cycle pulse on the last cycle of each period.

Function
REQ-014 One shared counter cnt SHALL count 0..PERIOD-1 and wrap to 0, with period_tick=1 exactly when cnt==PERIOD-1.
REQ-015 Per channel, the target SHALL equal min(duty_cycle_n, PERIOD); values >= PERIOD SHALL give 100% high, and 0 SHALL give constant low.
REQ-016 Effective duty duty_eff SHALL change only on period_tick cycles, moving toward the target by at most RAMP_STEP (or fully when RAMP_STEP=0), never overshooting.
REQ-017 Mid-period duty_cycle changes SHALL NOT affect the current period; this makes the output glitch-free.
REQ-018 The per-channel state machine SHALL have states OFF, RUN and DEAD.
REQ-019 In OFF: sig_out SHALL be 0, duty_eff SHALL be 0, and dir_out SHALL follow control bit1 with one cycle latency; enable=1 SHALL move the channel to RUN.
REQ-020 In RUN: sig_out SHALL equal (cnt < duty_eff), registered, so it lags cnt by one cycle.
REQ-021 In RUN: enable=0 SHALL move the channel to OFF, and sig_out SHALL be 0 from the next cycle.
REQ-022 In RUN: control bit1 != dir_out with enable=1 SHALL move the channel to DEAD, load the dead counter with DEADTIME-1, force sig_out to 0 from the next cycle, and clear duty_eff to 0.
REQ-023 In DEAD: the dead counter SHALL decrement each cycle while dir_out is held.
REQ-024 In DEAD, when the dead counter reaches 0, dir_out SHALL load the current control bit1 and the channel SHALL return to RUN, ramping from 0.
REQ-025 In DEAD: enable=0 SHALL take priority and move the channel to OFF immediately; a direction re-reversal SHALL NOT shorten the dead time.
REQ-026 When the enable fall and the direction change occur in the same cycle in RUN, OFF SHALL win.
REQ-027 Channels SHALL be fully independent except for the shared cnt and period_tick.

Reset
REQ-028 While resetN=0 at a refclk edge: cnt SHALL be 0, all channels SHALL be in OFF, duty_eff and the dead counters SHALL be 0, and sig_out, dir_out, dead_active and period_tick SHALL all be 0.
REQ-029 Reset asserted mid-DEAD or mid-period SHALL abort the operation with no residual state.

Structure
REQ-030 Package motor_pwm_pkg SHALL hold the state enum (OFF/RUN/DEAD) and the LOW/HIGH constants.
REQ-031 A per-channel sub-module motor_pwm_ch SHALL implement the state machine, ramp and output register, and SHALL be instantiated NUM_CH times via generate.
REQ-032 The shared counter SHALL reside in motor_pwm_mc.

Verification
REQ-033 Defaults, duty 25 on ch0, enable=1 -> after the ramp settles (5 periods), sig_out high exactly 25 of every 100 cycles, and period_tick every 100 cycles.
REQ-034 Duty 0->50, RAMP_STEP=5 -> duty_eff = 5,10,...,50 on successive period_ticks, reaching 50 after 10 ticks.
REQ-035 Running at 40, flip dir mid-period -> sig_out=0 and dead_active=1 for exactly 16 cycles, then dir_out toggles and duty restarts from 5.
REQ-036 Duty 150 (>PERIOD) -> sig_out is constant 1 once ramped; duty 0 -> sig_out is constant 0.
REQ-037 Enable drops during DEAD cycle 7 -> OFF the next cycle, sig_out=0, and dir_out follows control bit1.
REQ-038 resetN pulsed low mid-ramp on ch1 while ch0 runs -> all outputs 0, cnt=0; after release both channels ramp from 0.

Source files
------------

// File: rtl/motor_pwm_pkg.sv
// Shared types and helpers for the multi-channel motor PWM block.
package motor_pwm_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } ch_state_e;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  // Move cur toward tgt by at most step without overshooting; step 0 jumps.
  function automatic int ramp_toward(input int cur, input int tgt, input int step);
    int res;
    res = tgt;
    if (step > 32'sd0) begin
      if (tgt > cur + step) begin
        res = cur + step;
      end else if (tgt < cur - step) begin
        res = cur - step;
      end else begin
        res = tgt;
      end
    end else begin
      res = tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/motor_pwm_ch.sv
// One motor channel: OFF/RUN/DEAD sequencing, per-period duty ramp and
// registered PWM, direction and dead-time outputs.
module motor_pwm_ch
  import motor_pwm_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 100,
  parameter int DEADTIME  = 16,
  parameter int RAMP_STEP = 5
) (
  input  logic             refclk,
  input  logic             resetN,
  input  logic [CNT_W-1:0] cnt,
  input  logic             tick,
  input  logic [CNT_W-1:0] duty,
  input  logic             enable,
  input  logic             dir_req,
  output logic             sig_out,
  output logic             dir_out,
  output logic             dead_active
);

  localparam int               DT_W     = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DT_W-1:0]  DT_LOAD  = DT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] duty_eff_q, duty_eff_d, target_s;
  logic [DT_W-1:0]  dead_cnt_q, dead_cnt_d;
  logic             sig_q, sig_d, dir_q, dir_d, dead_q, dead_d;

  // Duty requests at or above the period saturate to 100% high.
  always_comb begin
    if (duty > PERIOD_C) begin
      target_s = PERIOD_C;
    end else begin
      target_s = duty;
    end
  end

  // Next-state, ramp and output decode; disable always beats a reversal.
  always_comb begin
    state_d    = state_q;
    duty_eff_d = duty_eff_q;
    dead_cnt_d = dead_cnt_q;
    dir_d      = dir_q;
    sig_d      = LOW;
    case (state_q)
      ST_OFF: begin
        duty_eff_d = '0;
        dead_cnt_d = '0;
        dir_d      = dir_req;
        if (enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d    = ST_OFF;
          duty_eff_d = '0;
        end else if (dir_req != dir_q) begin
          state_d    = ST_DEAD;
          dead_cnt_d = DT_LOAD;
          duty_eff_d = '0;
        end else begin
          sig_d = (cnt < duty_eff_q) ? HIGH : LOW;
          if (tick) begin
            duty_eff_d = CNT_W'(ramp_toward(int'(duty_eff_q), int'(target_s), RAMP_STEP));
          end else begin
            duty_eff_d = duty_eff_q;
          end
        end
      end
      ST_DEAD: begin
        if (!enable) begin
          state_d    = ST_OFF;
          duty_eff_d = '0;
          dead_cnt_d = '0;
        end else if (dead_cnt_q == '0) begin
          state_d = ST_RUN;
          dir_d   = dir_req;
        end else begin
          dead_cnt_d = dead_cnt_q - DT_W'(1);
        end
      end
      default: begin
        state_d    = ST_OFF;
        duty_eff_d = '0;
        dead_cnt_d = '0;
      end
    endcase
    dead_d = (state_d == ST_DEAD) ? HIGH : LOW;
  end

  // Channel state and output registers.
  always_ff @(posedge refclk) begin
    if (!resetN) begin
      state_q    <= ST_OFF;
      duty_eff_q <= '0;
      dead_cnt_q <= '0;
      sig_q      <= LOW;
      dir_q      <= LOW;
      dead_q     <= LOW;
    end else begin
      state_q    <= state_d;
      duty_eff_q <= duty_eff_d;
      dead_cnt_q <= dead_cnt_d;
      sig_q      <= sig_d;
      dir_q      <= dir_d;
      dead_q     <= dead_d;
    end
  end

  assign sig_out     = sig_q;
  assign dir_out     = dir_q;
  assign dead_active = dead_q;

endmodule

// File: rtl/motor_pwm_mc.sv
// Multi-channel motor PWM: one shared period counter feeding NUM_CH
// independent channels.
module motor_pwm_mc
  import motor_pwm_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 100,
  parameter int DEADTIME  = 16,
  parameter int RAMP_STEP = 5
) (
  input  logic                    refclk,
  input  logic                    resetN,
  input  logic [NUM_CH*CNT_W-1:0] duty_cycle,
  input  logic [NUM_CH*2-1:0]     control,
  output logic [NUM_CH-1:0]       sig_out,
  output logic [NUM_CH-1:0]       dir_out,
  output logic [NUM_CH-1:0]       dead_active,
  output logic                    period_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered from the next count so it is high exactly while cnt is LAST.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d = (cnt_d == LAST) ? HIGH : LOW;
  end

  // Shared period counter and tick register.
  always_ff @(posedge refclk) begin
    if (!resetN) begin
      cnt_q  <= '0;
      tick_q <= LOW;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign period_tick = tick_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    motor_pwm_ch #(
      .CNT_W     (CNT_W),
      .PERIOD    (PERIOD),
      .DEADTIME  (DEADTIME),
      .RAMP_STEP (RAMP_STEP)
    ) u_ch (
      .refclk      (refclk),
      .resetN      (resetN),
      .cnt         (cnt_q),
      .tick        (tick_q),
      .duty        (duty_cycle[g*CNT_W +: CNT_W]),
      .enable      (control[2*g]),
      .dir_req     (control[2*g+1]),
      .sig_out     (sig_out[g]),
      .dir_out     (dir_out[g]),
      .dead_active (dead_active[g])
    );
  end

endmodule

// File: tb/tb_motor_pwm_mc.sv
// Directed bench for motor_pwm_mc with a cycle-level behavioural reference model.
module tb_motor_pwm_mc;

  localparam int NCH  = 2;
  localparam int CW   = 8;
  localparam int PER  = 100;
  localparam int DT   = 16;
  localparam int STEP = 5;

  localparam logic [1:0] MD_OFF  = 2'd0;
  localparam logic [1:0] MD_RUN  = 2'd1;
  localparam logic [1:0] MD_DEAD = 2'd2;

  logic              refclk = 1'b0;
  logic              resetN = 1'b0;
  logic [NCH*CW-1:0] duty_cycle = '0;
  logic [NCH*2-1:0]  control = '0;
  logic [NCH-1:0]    sig_out, dir_out, dead_active;
  logic              period_tick;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  motor_pwm_mc #(
    .NUM_CH(NCH), .CNT_W(CW), .PERIOD(PER), .DEADTIME(DT), .RAMP_STEP(STEP)
  ) dut (
    .refclk      (refclk),
    .resetN      (resetN),
    .duty_cycle  (duty_cycle),
    .control     (control),
    .sig_out     (sig_out),
    .dir_out     (dir_out),
    .dead_active (dead_active),
    .period_tick (period_tick)
  );

  always #5 refclk = ~refclk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] eff;
    logic [31:0] dead_end;
    logic        dir;
    logic        sig;
    logic        dead;
  } mch_t;

  mch_t m_ch [NCH];
  int   m_cnt  = 0;
  logic m_tick = 1'b0;
  int   m_cyc  = 0;

  function automatic mch_t ch_next(input mch_t c, input int cyc, input int cnt,
                                   input int duty, input bit en, input bit dreq);
    mch_t n;
    int   tgt, diff;
    n     = c;
    n.sig = 1'b0;
    tgt   = (duty < PER) ? duty : PER;
    if (c.mode == MD_OFF) begin
      n.eff = 32'd0;
      n.dir = dreq;
      if (en) n.mode = MD_RUN;
    end else if (!en) begin
      n.mode = MD_OFF;
      n.eff  = 32'd0;
    end else if (c.mode == MD_DEAD) begin
      if (cyc == int'(c.dead_end)) begin
        n.mode = MD_RUN;
        n.dir  = dreq;
      end
    end else if (dreq != c.dir) begin
      n.mode     = MD_DEAD;
      n.dead_end = 32'(cyc + DT);
      n.eff      = 32'd0;
    end else begin
      n.sig = (cnt < int'(c.eff));
      if (cnt == PER - 1) begin
        diff = tgt - int'(c.eff);
        if (STEP == 0 || (diff <= STEP && diff >= -STEP)) n.eff = 32'(tgt);
        else n.eff = 32'(int'(c.eff) + ((diff > 0) ? STEP : -STEP));
      end
    end
    n.dead = (n.mode == MD_DEAD);
    return n;
  endfunction

  always @(posedge refclk) begin
    m_cyc <= m_cyc + 1;
    if (!resetN) begin
      m_cnt  <= 0;
      m_tick <= 1'b0;
      for (int i = 0; i < NCH; i++) m_ch[i] <= '0;
    end else begin
      m_cnt  <= (m_cnt + 1) % PER;
      m_tick <= (((m_cnt + 1) % PER) == PER - 1);
      for (int i = 0; i < NCH; i++)
        m_ch[i] <= ch_next(m_ch[i], m_cyc, m_cnt, int'(duty_cycle[i*CW +: CW]),
                           control[2*i], control[2*i+1]);
    end
  end

  // ---------------- checking ----------------
  task automatic check_bit(input string nm, input int ch, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0b, expected %0b at %0t", nm, ch, act, exp, $time);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge refclk) begin
    if (chk_on) begin
      for (int i = 0; i < NCH; i++) begin
        check_bit("sig_out", i, sig_out[i], m_ch[i].sig);
        check_bit("dir_out", i, dir_out[i], m_ch[i].dir);
        check_bit("dead_active", i, dead_active[i], m_ch[i].dead);
      end
      check_bit("period_tick", 0, period_tick, m_tick);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ch(input int ch, input int duty, input bit en, input bit dir);
    duty_cycle[ch*CW +: CW] = CW'(duty);
    control[2*ch]           = en;
    control[2*ch+1]         = dir;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic count_high(input int ch, input int n, output int highs, output int ticks);
    highs = 0;
    ticks = 0;
    repeat (n) begin
      @(negedge refclk);
      highs += int'(sig_out[ch]);
      ticks += int'(period_tick);
    end
  endtask

  task automatic wait_tick();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge refclk);
      if (period_tick) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val("period_tick_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, t, d, n;
    // Reset state
    cycles(3);
    check_val("reset_sig", int'(sig_out), 0);
    check_val("reset_dir", int'(dir_out), 0);
    check_val("reset_dead", int'(dead_active), 0);
    check_val("reset_tick", int'(period_tick), 0);
    chk_on = 1'b1;
    resetN = 1'b1;

    // Duty 25 on ch0 settles to 25 highs and one tick per 100 cycles
    set_ch(0, 25, 1'b1, 1'b0);
    cycles(700);
    count_high(0, PER, h, t);
    check_val("duty25_highs", h, 25);
    check_val("duty25_ticks", t, 1);

    // Ramp 0 -> 50 on ch1 in steps of 5
    wait_tick();
    set_ch(1, 50, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      wait_tick();
      @(negedge refclk);
      check_val("ramp_eff", int'(m_ch[1].eff), 5 * k);
    end
    count_high(1, PER, h, t);
    check_val("duty50_highs", h, 50);

    // Direction reversal at duty 40
    set_ch(0, 40, 1'b1, 1'b0);
    cycles(500);
    wait_tick();
    cycles(30);
    set_ch(0, 40, 1'b1, 1'b1);
    d = 0;
    h = 0;
    repeat (40) begin
      @(negedge refclk);
      d += int'(dead_active[0]);
      h += int'(sig_out[0]);
    end
    check_val("dead_cycles", d, DT);
    check_val("dead_sig_highs", h, 0);
    check_val("dir_after_dead", int'(dir_out[0]), 1);
    wait_tick();
    @(negedge refclk);
    check_val("restart_eff", int'(m_ch[0].eff), 5);
    count_high(0, PER, h, t);
    check_val("restart_highs", h, 5);

    // Saturation above PERIOD, then zero duty
    set_ch(1, 150, 1'b1, 1'b0);
    cycles(1300);
    count_high(1, PER, h, t);
    check_val("duty150_highs", h, PER);
    set_ch(1, 0, 1'b1, 1'b0);
    cycles(2200);
    count_high(1, PER, h, t);
    check_val("duty0_highs", h, 0);

    // Enable drop in the middle of dead time
    set_ch(0, 40, 1'b1, 1'b0);
    cycles(7);
    check_val("dead_mid", int'(dead_active[0]), 1);
    set_ch(0, 40, 1'b0, 1'b0);
    @(negedge refclk);
    check_val("off_dead", int'(dead_active[0]), 0);
    check_val("off_sig", int'(sig_out[0]), 0);
    set_ch(0, 40, 1'b0, 1'b1);
    @(negedge refclk);
    check_val("off_dir_follow1", int'(dir_out[0]), 1);
    set_ch(0, 40, 1'b0, 1'b0);
    @(negedge refclk);
    check_val("off_dir_follow0", int'(dir_out[0]), 0);

    // Reset mid-ramp with both channels running
    set_ch(0, 40, 1'b1, 1'b0);
    set_ch(1, 60, 1'b1, 1'b0);
    wait_tick();
    cycles(237);
    resetN = 1'b0;
    cycles(2);
    check_val("rst2_sig", int'(sig_out), 0);
    check_val("rst2_dir", int'(dir_out), 0);
    check_val("rst2_dead", int'(dead_active), 0);
    check_val("rst2_tick", int'(period_tick), 0);
    resetN = 1'b1;
    n = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge refclk);
      n++;
      if (period_tick) break;
    end
    check_val("first_tick_delay", n, PER - 1);
    @(negedge refclk);
    check_val("rst2_eff0", int'(m_ch[0].eff), 5);
    check_val("rst2_eff1", int'(m_ch[1].eff), 5);
    count_high(0, PER, h, t);
    check_val("rst2_highs0", h, 5);
    set_ch(1, 60, 1'b1, 1'b0);
    wait_tick();
    @(negedge refclk);
    count_high(1, PER, h, t);
    check_val("rst2_highs1", h, 15);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
